// File: rtl/adder_serial_ctrl.sv
// Bit-serial adder controller: one shared full adder, LSB first, valid/ready on both sides.
// Optional signed-overflow output o_ovf is enabled by defining ADDER_SERIAL_CTRL_OVF_EN.

module adder_1bit_full (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_serial_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry,
`ifdef ADDER_SERIAL_CTRL_OVF_EN
  output logic                  o_ovf,
`endif
  output logic                  o_busy
);

  localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] sa_q;
  logic [DATA_WIDTH-1:0] sb_q;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_nxt;
  logic [DATA_WIDTH-1:0] res_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  cr_q;
  logic                  cry_q;
  logic                  sum_bit;
  logic                  cout_bit;
  logic                  last_bit;

  adder_1bit_full u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (cr_q),
    .sum  (sum_bit),
    .cout (cout_bit)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  generate
    if (DATA_WIDTH == 1) begin : g_sr_w1
      assign sr_nxt = sum_bit;
    end else begin : g_sr_wn
      assign sr_nxt = {sum_bit, sr_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    o_rdy   = 1'b0;
    o_vld   = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        o_rdy = 1'b1;
        if (i_vld) state_d = CALC;
      end
      CALC: begin
        o_busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        o_vld  = 1'b1;
        o_busy = 1'b1;
        if (i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Result is copied out only on the final bit, so o_res never shows a partial sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      sr_q  <= '0;
      cr_q  <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      cry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_vld) begin
            sa_q  <= i_num_a;
            sb_q  <= i_num_b;
            cr_q  <= i_cry;
            cnt_q <= '0;
          end
        end
        CALC: begin
          sa_q <= sa_q >> 1;
          sb_q <= sb_q >> 1;
          sr_q <= sr_nxt;
          cr_q <= cout_bit;
          if (last_bit) begin
            res_q <= sr_nxt;
            cry_q <= cout_bit;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_SERIAL_CTRL_OVF_EN
  logic cmsb_q;

  // cr_q during the last CALC cycle is the carry into the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        cmsb_q <= 1'b0;
    else if (state_q == CALC && last_bit) cmsb_q <= cr_q;
  end

  assign o_ovf = cmsb_q ^ cry_q;
`endif

  assign o_res = res_q;
  assign o_cry = cry_q;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed self-checking bench for adder_serial_ctrl: an 8-bit instance for arithmetic and
// handshakes, plus a 1-bit instance swept over the full-adder truth table.

module tb_adder_serial_ctrl;

  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       vld   = 1'b0;
  logic       rdy   = 1'b1;
  logic       cin   = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic       o_rdy, o_vld, o_cry, o_busy;
  logic [7:0] o_res;

  logic       vld1 = 1'b0;
  logic       rdy1 = 1'b1;
  logic [0:0] a1   = '0;
  logic [0:0] b1   = '0;
  logic       cin1 = 1'b0;
  logic       o_rdy1, o_vld1, o_cry1, o_busy1;
  logic [0:0] o_res1;

`ifdef ADDER_SERIAL_CTRL_OVF_EN
  logic o_ovf, o_ovf1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_serial_ctrl #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (vld),
    .o_rdy   (o_rdy),
    .i_num_a (a),
    .i_num_b (b),
    .i_cry   (cin),
    .o_vld   (o_vld),
    .i_rdy   (rdy),
    .o_res   (o_res),
    .o_cry   (o_cry),
`ifdef ADDER_SERIAL_CTRL_OVF_EN
    .o_ovf   (o_ovf),
`endif
    .o_busy  (o_busy)
  );

  adder_serial_ctrl #(.DATA_WIDTH(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (vld1),
    .o_rdy   (o_rdy1),
    .i_num_a (a1),
    .i_num_b (b1),
    .i_cry   (cin1),
    .o_vld   (o_vld1),
    .i_rdy   (rdy1),
    .o_res   (o_res1),
    .o_cry   (o_cry1),
`ifdef ADDER_SERIAL_CTRL_OVF_EN
    .o_ovf   (o_ovf1),
`endif
    .o_busy  (o_busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; stops #1 after the edge that raises o_vld.
  task automatic wait_vld(input string tag, input int exp_cyc, input logic [7:0] prev_res);
    int cyc = 0;
    while (cyc < 4 * W) begin
      @(posedge clk); #1;
      cyc++;
      if (o_vld) break;
      check({tag, " calc_busy"}, o_busy, 1);
      check({tag, " calc_rdy"},  o_rdy,  0);
      check({tag, " calc_res"},  o_res,  prev_res);
    end
    check({tag, " latency"}, cyc, exp_cyc);
  endtask

  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_c, input logic [7:0] exp_res, input logic exp_cry,
                        input logic exp_ovf);
    logic [7:0] prev;
    prev = o_res;
    check({tag, " idle_rdy"}, o_rdy, 1);
    a = op_a; b = op_b; cin = op_c; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    a = ~op_a; b = ~op_b; cin = ~op_c;
    wait_vld(tag, W, prev);
    check({tag, " res"}, o_res, exp_res);
    check({tag, " cry"}, o_cry, exp_cry);
`ifdef ADDER_SERIAL_CTRL_OVF_EN
    check({tag, " ovf"}, o_ovf, exp_ovf);
`endif
    @(posedge clk); #1;
    check({tag, " post_rdy"}, o_rdy, 1);
    check({tag, " post_vld"}, o_vld, 0);
    check({tag, " post_res"}, o_res, exp_res);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    int         s;

    #2 rst_n = 1'b0;
    #1;
    check("rst rdy",  o_rdy,  1);
    check("rst vld",  o_vld,  0);
    check("rst busy", o_busy, 0);
    check("rst res",  o_res,  0);
    check("rst cry",  o_cry,  0);
`ifdef ADDER_SERIAL_CTRL_OVF_EN
    check("rst ovf",  o_ovf,  0);
`endif
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic",  8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("chain1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("chain2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Backpressure: result held, second request waits for the handshake.
    rdy = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b0; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    wait_vld("bp", W, 8'hFF);
    check("bp res", o_res, 8'h46);
    check("bp cry", o_cry, 0);
    a = 8'hAA; b = 8'h01; cin = 1'b0; vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold_vld", o_vld, 1);
      check("bp hold_res", o_res, 8'h46);
      check("bp hold_rdy", o_rdy, 0);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    check("bp ack_rdy", o_rdy, 1);
    check("bp ack_vld", o_vld, 0);
    @(posedge clk); #1;
    vld = 1'b0;
    wait_vld("bp2", W, 8'h46);
    check("bp2 res", o_res, 8'hAB);
    check("bp2 cry", o_cry, 0);
    @(posedge clk); #1;

    // Reset during the third CALC cycle discards the transaction.
    a = 8'h0F; b = 8'h01; cin = 1'b0; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst res",  o_res,  0);
    check("midrst cry",  o_cry,  0);
    check("midrst vld",  o_vld,  0);
    check("midrst busy", o_busy, 0);
    check("midrst rdy",  o_rdy,  1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst post_rdy",  o_rdy,  1);
    check("midrst post_busy", o_busy, 0);
    check("midrst post_vld",  o_vld,  0);
    run_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // DATA_WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      s = int'(v[2]) + int'(v[1]) + int'(v[0]);
      check("w1 rdy", o_rdy1, 1);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; vld1 = 1'b1;
      @(posedge clk); #1;
      vld1 = 1'b0;
      check("w1 calc_busy", o_busy1, 1);
      check("w1 calc_vld",  o_vld1,  0);
      @(posedge clk); #1;
      check("w1 vld", o_vld1, 1);
      check("w1 res", o_res1, 32'(s & 1));
      check("w1 cry", o_cry1, 32'(s >> 1));
      @(posedge clk); #1;
      check("w1 post_vld", o_vld1, 0);
    end

    run_op("ovf_7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("ovf_8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("ovf_0503", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
